beat_grid_scheduler: RTL
========================

# beat_grid_scheduler

Sequences the shared 35×35 instrument sprite ROM/palette path across the on-screen beat grid: 4 instrument rows × 16 steps of 35×35-pixel cells. Tracks the VGA raster with incremental cell counters (no dividers) and issues a ROM address and sprite select for each pixel. It also reports the pattern bit and playhead state per pixel, and runs the frame-based tempo counter that advances the playhead. Sits between the VGA controller (DrawX/DrawY/blank) and the sprite ROM/palette/colour-mapper stage.

## Interface
Parameters:
- X0, 40, left pixel column of the grid
- Y0, 100, top pixel row of the grid
- CELL, 35, cell edge in pixels; equals the sprite dimension
- COLS, 16, steps per row
- ROWS, 4, instrument rows

Ports:
- vga_clk  in  1  pixel clock; the only clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column; increments once per vga_clk
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- run  in  1  1 = playhead advances
- frames_per_step  in  6  frames per step; 0 is treated as 1
- pattern  in  64  step enables; bit index row*16+col
- rom_address  out  11  sprite ROM address = yoff*CELL + xoff
- sprite_sel  out  2  instrument row of the current cell; selects the ROM/palette
- in_grid  out  1  current pixel lies inside the grid and blank=1
- step_on  out  1  pattern bit of the current cell
- playhead_hit  out  1  current cell column == playhead
- playhead  out  4  current step
- step_pulse  out  1  one-cycle pulse when the playhead advances

## Operation
- X tracker (state x_valid, col, xoff). Evaluated every cycle:
  - DrawX==X0: x_valid=1, col=0, xoff=0.
  - Otherwise, if x_valid:
    - xoff==CELL-1: xoff=0, col=col+1.
    - col==COLS-1 and xoff==CELL-1: x_valid=0.
    - Any other case: xoff=xoff+1.
- Y tracker (state y_valid, row, yoff, ybase). Evaluated only on cycles with DrawX==0:
  - DrawY==Y0: y_valid=1, row=0, yoff=0, ybase=0.
  - Otherwise, if y_valid:
    - yoff==CELL-1: yoff=0, ybase=0, row=row+1.
    - row==ROWS-1 and yoff==CELL-1: y_valid=0.
    - Any other case: yoff=yoff+1, ybase=ybase+CELL.
- Pixel outputs, from registered state:
  - in_grid = x_valid & y_valid & blank_q, where blank_q is blank registered.
  - When in_grid: rom_address = ybase+xoff (11-bit, maximum 1224), sprite_sel=row, step_on=pattern[row*16+col], playhead_hit=(col==playhead).
  - When !in_grid: rom_address=0, sprite_sel=0, step_on=0, playhead_hit=0.
- Tempo:
  - frame_tick = (DrawX==0 && DrawY==0), 1 cycle per frame.
  - On frame_tick with run=1: if frame_cnt == max(frames_per_step,1)-1, then frame_cnt=0, playhead=playhead+1 (mod 16), step_pulse=1. Otherwise frame_cnt=frame_cnt+1.
  - run=0: frame_cnt forced to 0, playhead holds, step_pulse=0.
  - The playhead changes only on frame_tick, so there is no mid-frame tearing.
- frames_per_step changed mid-count: the new value applies at the next compare. If frame_cnt is already ≥ the new terminal value, frame_cnt keeps counting and wraps at 63. Software avoids this case by toggling run.

## Timing
- Latency: all outputs reflect the DrawX/DrawY/blank sampled on the previous vga_clk edge (1 cycle). The downstream ROM samples rom_address on negedge, and palette output is registered on the next posedge.
- step_pulse is high for exactly the cycle after the terminal frame_tick.
- Reset, registered outputs and state: x_valid=0, y_valid=0, col=row=xoff=yoff=ybase=0, frame_cnt=0, playhead=0, step_pulse=0, blank_q=0.
- Reset, derived outputs: all pixel outputs read 0, because in_grid=0 while x_valid, y_valid and blank_q are 0.
- Reset mid-frame: the grid stays dark until the next line with DrawY==Y0. The playhead restarts at 0.
- run rising: the first step_pulse comes on the frames_per_step-th frame_tick after run goes high.
- Simultaneous DrawX==X0 and x_valid=1 (e.g. X0 crossed again): the restart wins.

## Test plan
- Reset, then a full 640×480 frame with pattern=0 → in_grid=1 exactly for X 40..599, Y 100..239 (delayed 1 cycle); total 78,400 in_grid cycles; all outputs 0 during Reset.
- Pixel (X=40+35*3+7, Y=100+35*2+4) → sprite_sel=2, rom_address=4*35+7=147; step_on follows pattern bit 35.
- Last grid pixel (599,239) → rom_address=1224, sprite_sel=3; pixel (600,239) → in_grid=0, rom_address=0.
- run=1, frames_per_step=3 → step_pulse on frame ticks 3, 6, 9…; playhead 0→1→2; after 16 steps it wraps 15→0. frames_per_step=0 → a step every frame.
- run dropped mid-count → playhead holds and no pulse; run raised again → the next step comes after a full frames_per_step frames.
- Reset asserted at Y=150 → in_grid=0 for the rest of the frame and playhead=0; the grid reappears on the next frame at Y=100.

Source files
------------

// File: rtl/beat_grid_scheduler.sv
// Beat grid raster tracker: maps the VGA raster onto a 4x16 grid of 35x35
// cells, drives sprite ROM address/select and runs the playhead tempo.
//
// Ports:
//   vga_clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank     raster position and active-video flag
//   run, frames_per_step    tempo control (0 frames treated as 1)
//   pattern                 step enables, bit index row*16+col
//   rom_address, sprite_sel sprite ROM address and instrument select
//   in_grid, step_on        pixel inside grid, pattern bit of its cell
//   playhead_hit            cell column equals playhead
//   playhead, step_pulse    current step and one-cycle advance pulse
module beat_grid_scheduler #(
  parameter int X0   = 40,
  parameter int Y0   = 100,
  parameter int CELL = 35,
  parameter int COLS = 16,
  parameter int ROWS = 4
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        run,
  input  logic [5:0]  frames_per_step,
  input  logic [63:0] pattern,
  output logic [10:0] rom_address,
  output logic [1:0]  sprite_sel,
  output logic        in_grid,
  output logic        step_on,
  output logic        playhead_hit,
  output logic [3:0]  playhead,
  output logic        step_pulse
);

  localparam logic [9:0]  X0_V     = 10'(X0);
  localparam logic [9:0]  Y0_V     = 10'(Y0);
  localparam logic [5:0]  CELL_M1  = 6'(CELL - 1);
  localparam logic [10:0] CELL_V   = 11'(CELL);
  localparam logic [3:0]  COL_LAST = 4'(COLS - 1);
  localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);

  logic        x_valid;
  logic [3:0]  col;
  logic [5:0]  xoff;
  logic        y_valid;
  logic [1:0]  row;
  logic [5:0]  yoff;
  logic [10:0] ybase;
  logic        blank_q;
  logic [5:0]  frame_cnt;
  logic        frame_tick;
  logic [5:0]  fps_term;

  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign fps_term   = (frames_per_step == 6'd0) ? 6'd0
                                                : frames_per_step - 6'd1;

  // Horizontal cell tracking; crossing X0 again restarts the line.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_valid <= 1'b0;
      col     <= '0;
      xoff    <= '0;
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank;
      if (DrawX == X0_V) begin
        x_valid <= 1'b1;
        col     <= '0;
        xoff    <= '0;
      end else if (x_valid) begin
        if (xoff == CELL_M1) begin
          xoff <= '0;
          col  <= col + 4'd1;
          if (col == COL_LAST)
            x_valid <= 1'b0;
        end else begin
          xoff <= xoff + 6'd1;
        end
      end
    end
  end

  // Vertical tracking advances once per line, at DrawX==0.
  // ybase carries yoff*CELL so no multiplier is needed.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      y_valid <= 1'b0;
      row     <= '0;
      yoff    <= '0;
      ybase   <= '0;
    end else if (DrawX == 10'd0) begin
      if (DrawY == Y0_V) begin
        y_valid <= 1'b1;
        row     <= '0;
        yoff    <= '0;
        ybase   <= '0;
      end else if (y_valid) begin
        if (yoff == CELL_M1) begin
          yoff  <= '0;
          ybase <= '0;
          row   <= row + 2'd1;
          if (row == ROW_LAST)
            y_valid <= 1'b0;
        end else begin
          yoff  <= yoff + 6'd1;
          ybase <= ybase + CELL_V;
        end
      end
    end
  end

  // Tempo: playhead only moves on the frame tick, never mid-frame.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      frame_cnt  <= '0;
      playhead   <= '0;
      step_pulse <= 1'b0;
    end else if (!run) begin
      frame_cnt  <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (frame_tick) begin
        if (frame_cnt == fps_term) begin
          frame_cnt  <= '0;
          playhead   <= playhead + 4'd1;
          step_pulse <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end
  end

  always_comb begin
    in_grid      = x_valid & y_valid & blank_q;
    rom_address  = '0;
    sprite_sel   = '0;
    step_on      = 1'b0;
    playhead_hit = 1'b0;
    if (in_grid) begin
      rom_address  = ybase + {5'd0, xoff};
      sprite_sel   = row;
      step_on      = pattern[{row, col}];
      playhead_hit = (col == playhead);
    end
  end

endmodule
